// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - op codes, FSM states and op classification for the MEM-stage access unit
package mem_pkg;

   typedef enum logic [3:0] {
      OP_LW  = 4'd0,
      OP_LB  = 4'd1,
      OP_LBU = 4'd2,
      OP_LH  = 4'd3,
      OP_LHU = 4'd4,
      OP_LWL = 4'd5,
      OP_LWR = 4'd6,
      OP_SW  = 4'd7,
      OP_SB  = 4'd8,
      OP_SH  = 4'd9,
      OP_SWL = 4'd10,
      OP_SWR = 4'd11,
      OP_NOP = 4'd15
   } op_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_WRITE = 1'b1
   } state_e;

   function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] b);
      case (op)
         OP_LH, OP_LHU, OP_SH: return b[0];
         OP_LW, OP_SW:         return b != 2'd0;
         default:              return 1'b0;
      endcase
   endfunction

   function automatic logic is_load(input logic [3:0] op);
      return op inside {OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LWL, OP_LWR};
   endfunction

   // Stores that cover the whole word need no read of the old contents
   function automatic logic is_full_store(input logic [3:0] op, input logic [1:0] b);
      return (op == OP_SW && b == 2'd0) || (op == OP_SWL && b == 2'd0) ||
             (op == OP_SWR && b == 2'd3);
   endfunction

   function automatic logic is_rmw(input logic [3:0] op, input logic [1:0] b);
      case (op)
         OP_SB:   return 1'b1;
         OP_SH:   return !b[0];
         OP_SWL:  return b != 2'd0;
         OP_SWR:  return b != 2'd3;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_align_merge.sv
// rtl/mem_align_merge.sv - big-endian load alignment/extension and store-word merge
module mem_align_merge
   import mem_pkg::*;
(
   input  logic [3:0]  op_i,
   input  logic [1:0]  b_i,
   input  logic [31:0] w_i,
   input  logic [31:0] rt_i,
   output logic [31:0] load_o,
   output logic [31:0] store_o
);

   logic [4:0]  sh_b;
   logic [4:0]  sh_nb;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Byte 0 sits in the MSBs, so 8*(3-b) brings byte b down to bit 0
   assign sh_b  = {b_i, 3'b000};
   assign sh_nb = {~b_i, 3'b000};

   always_comb begin
      byte_sel = 8'(w_i >> sh_nb);
      half_sel = b_i[1] ? w_i[15:0] : w_i[31:16];
      load_o   = w_i;
      case (op_i)
         OP_LB:   load_o = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  load_o = {24'd0, byte_sel};
         OP_LH:   load_o = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  load_o = {16'd0, half_sel};
         OP_LWL:  load_o = (w_i << sh_b) | (rt_i & ~(32'hFFFF_FFFF << sh_b));
         OP_LWR:  load_o = (w_i >> sh_nb) | (rt_i & ~(32'hFFFF_FFFF >> sh_nb));
         default: load_o = w_i;
      endcase

      store_o = rt_i;
      case (op_i)
         OP_SB:   store_o = (w_i & ~(32'hFF00_0000 >> sh_b)) | ({24'd0, rt_i[7:0]} << sh_nb);
         OP_SH:   store_o = b_i[1] ? {w_i[31:16], rt_i[15:0]} : {rt_i[15:0], w_i[15:0]};
         OP_SWL:  store_o = (w_i & ~(32'hFFFF_FFFF >> sh_b)) | (rt_i >> sh_b);
         OP_SWR:  store_o = (w_i & ~(32'hFFFF_FFFF << sh_nb)) | (rt_i << sh_nb);
         default: store_o = rt_i;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit with RMW FSM and MEM/WB result register
module mem_access_unit
   import mem_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [3:0]  in_op,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_wdata,
   input  logic [4:0]  in_rd,
   output logic        stall,
   output logic        Mem_Wr_en,
   output logic [31:0] Data_Addr,
   output logic [31:0] Din,
   input  logic [31:0] Dout,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        addr_err
);

   state_e      state_q, state_d;
   logic [3:0]  op_q;
   logic [1:0]  b_q;
   logic [31:0] w_q, rt_q;
   logic [29:0] waddr_q;
   logic        wb_valid_q, addr_err_q;
   logic [4:0]  wb_rd_q;
   logic [31:0] wb_data_q;

   logic [1:0]  b;
   logic        misal, take_rmw, take_load;
   logic [3:0]  m_op;
   logic [1:0]  m_b;
   logic [31:0] m_w, m_rt, load_data, store_word;

   assign b     = in_addr[1:0];
   assign misal = in_valid && is_misaligned(in_op, b);

   always_comb begin
      state_d   = state_q;
      stall     = 1'b0;
      Mem_Wr_en = 1'b0;
      take_rmw  = 1'b0;
      take_load = 1'b0;
      Data_Addr = {in_addr[31:2], 2'b00};
      m_op      = in_op;
      m_b       = b;
      m_w       = Dout;
      m_rt      = in_wdata;
      case (state_q)
         ST_IDLE: begin
            take_rmw  = in_valid && is_rmw(in_op, b);
            take_load = in_valid && is_load(in_op) && !misal;
            stall     = take_rmw;
            Mem_Wr_en = in_valid && is_full_store(in_op, b);
            if (take_rmw) state_d = ST_WRITE;
         end
         ST_WRITE: begin
            // Upstream is free again; only latched copies drive the merge
            Mem_Wr_en = 1'b1;
            Data_Addr = {waddr_q, 2'b00};
            m_op      = op_q;
            m_b       = b_q;
            m_w       = w_q;
            m_rt      = rt_q;
            state_d   = ST_IDLE;
         end
      endcase
      // Reset must kill an in-flight write before the falling edge commits it
      if (rst) begin
         Mem_Wr_en = 1'b0;
         stall     = 1'b0;
      end
   end

   mem_align_merge u_align_merge (
      .op_i    (m_op),
      .b_i     (m_b),
      .w_i     (m_w),
      .rt_i    (m_rt),
      .load_o  (load_data),
      .store_o (store_word)
   );

   assign Din = store_word;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         op_q       <= OP_NOP;
         b_q        <= 2'd0;
         w_q        <= 32'd0;
         rt_q       <= 32'd0;
         waddr_q    <= 30'd0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= 5'd0;
         wb_data_q  <= 32'd0;
         addr_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wb_valid_q <= take_load;
         addr_err_q <= (state_q == ST_IDLE) && misal;
         if (take_rmw) begin
            op_q    <= in_op;
            b_q     <= b;
            w_q     <= Dout;
            rt_q    <= in_wdata;
            waddr_q <= in_addr[31:2];
         end
         if (take_load) begin
            wb_rd_q   <= in_rd;
            wb_data_q <= load_data;
         end
      end
   end

   assign wb_valid = wb_valid_q;
   assign wb_rd    = wb_rd_q;
   assign wb_data  = wb_data_q;
   assign addr_err = addr_err_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage access unit sitting directly upstream of the pipeline's byte-addressed, big-endian data memory: it turns EX/MEM load/store requests into word-aligned memory accesses and doubles as the MEM/WB result register. The memory only supports full 32-bit writes, so sub-word and partial stores (SB, SH, SWL, SWR) run a two-cycle read-modify-write that stalls the upstream stage. Loads are aligned, sign- or zero-extended, or merged (LWL/LWR), and registered for writeback.

## Interface
- No parameters; widths fixed at 32-bit data/address, 5-bit register index.
- clk  in  1  pipeline clock, rising-edge state; memory writes at the falling edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  EX/MEM holds a valid memory op
- in_op  in  4  op code (see Structure)
- in_addr  in  32  effective byte address
- in_wdata  in  32  rt value: store data, and the old rt for LWL/LWR merge
- in_rd  in  5  destination register for loads
- stall  out  1  hold EX/MEM and earlier stages this cycle
- Mem_Wr_en  out  1  memory write enable
- Data_Addr  out  32  word-aligned address, {in_addr[31:2],2'b00}
- Din  out  32  memory write data
- Dout  in  32  combinational memory read data at Data_Addr
- wb_valid  out  1  registered load result valid
- wb_rd  out  5  registered destination
- wb_data  out  32  registered load result
- addr_err  out  1  registered misaligned LH/LHU/LW/SH/SW pulse

## Operation
- Byte offset b = in_addr[1:0]. Word W = Dout; byte 0 = W[31:24] (big-endian).
- Loads: LB/LBU select byte b, sign/zero extend. LH/LHU select halfword b (b∈{0,2}). LW = W. LWL = (W<<8b) | (rt & ((1<<8b)-1)). LWR = (W>>8(3-b)) | (rt & ~(32'hFFFFFFFF>>8(3-b))).
- Stores: SW, SWL with b=0, and SWR with b=3 are full-word writes done in one cycle: Mem_Wr_en=1, Din=the full word.
- RMW stores: SB, SH, all other SWL/SWR. The merged word is:
  - SB: byte b replaced by rt[7:0].
  - SH: halfword b replaced by rt[15:0].
  - SWL: (W & ~(32'hFFFFFFFF>>8b)) | (rt>>8b).
  - SWR: (W & ~(32'hFFFFFFFF<<8(3-b))) | (rt<<8(3-b)).
- Misaligned LH/LHU (b odd), LW/SW (b≠0), SH (b odd): no memory write, no wb_valid; addr_err=1 for one cycle.
- FSM IDLE/WRITE:
  - IDLE + valid RMW store → WRITE. Latch W, the op, b and rt.
  - WRITE → IDLE unconditionally. In_* are ignored while in WRITE; the latched copies are used.
- NOP op or in_valid=0: no write; wb_valid=0 next cycle.

## Timing
- Reset: state IDLE; wb_valid=0, wb_rd=0, wb_data=0, addr_err=0. Mem_Wr_en=0 and stall=0 immediately, since both are decoded combinationally from state and inputs.
- Load accepted in cycle N: wb_* valid in cycle N+1, one cycle only.
- Single-cycle store in cycle N: Mem_Wr_en=1 during N; memory commits at the N falling edge.
- RMW store:
  - Cycle N: stall=1, Mem_Wr_en=0; W is captured at the rising edge ending N.
  - Cycle N+1: state WRITE, stall=0, Mem_Wr_en=1, Din=merged word, Data_Addr=latched aligned address.
  - Upstream advances at the end of N+1.
- Stores never assert wb_valid.
- rst asserted during WRITE: Mem_Wr_en drops asynchronously and no partial write occurs. The store is lost; the pipeline is flushed by the same reset.

## Structure
- Shared package mem_pkg holds:
  - Op codes: LW=0, LB=1, LBU=2, LH=3, LHU=4, LWL=5, LWR=6, SW=7, SB=8, SH=9, SWL=10, SWR=11, NOP=15.
  - FSM state enum.
  - An is_rmw() classification function.
- One sub-module, mem_align_merge: purely combinational; produces the load result and the merged store word from (op, b, W, rt). The top level holds the FSM and registers.

## Test plan
- Memory word at 128 = 0xF11F3DD3:
  - LB @128 → wb_data=0xFFFFFFF1.
  - LBU @128 → 0x000000F1.
  - LB @129 → 0x0000001F.
  - Each result appears exactly one cycle after issue.
- SB @130, rt=0x000000AA → stall=1 in N; in N+1 Mem_Wr_en=1, Data_Addr=128, Din=0xF11FAAD3.
- LWL @129, rt=0x11223344 → wb_data=0x1F3DD344. LWR @129, same rt → 0x1122F11F.
- SWR @130, rt=0xAABBCCDD → Din=0xBBCCDDD3. SWL @128 → single cycle, Din=0xAABBCCDD, stall=0.
- LH @129 → addr_err=1 for one cycle, wb_valid=0, Mem_Wr_en=0.
- rst pulsed during WRITE of SB → Mem_Wr_en=0 immediately, word at 128 unchanged, state IDLE.
